// File: rtl/ula_arb_pkg.sv
// Shared constants for the ula_arb slice: R-type operation codes, FSM states and field widths.
package ula_arb_pkg;

    localparam int OPCODE_W = 7;
    localparam int FUNCT3_W = 3;
    localparam int FUNCT7_W = 7;
    localparam int CODE_W   = OPCODE_W + FUNCT3_W + FUNCT7_W;

    // Codes are {opcode, funct3, funct7}.
    localparam logic [CODE_W-1:0] ADD_OP = 17'b0110011_000_0000000;
    localparam logic [CODE_W-1:0] SUB_OP = 17'b0110011_000_0100000;
    localparam logic [CODE_W-1:0] SLL_OP = 17'b0110011_001_0000000;
    localparam logic [CODE_W-1:0] SRL_OP = 17'b0110011_101_0000000;
    localparam logic [CODE_W-1:0] XOR_OP = 17'b0110011_100_0000000;
    localparam logic [CODE_W-1:0] OR_OP  = 17'b0110011_110_0000000;
    localparam logic [CODE_W-1:0] AND_OP = 17'b0110011_111_0000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic code_illegal(input logic [CODE_W-1:0] code);
        case (code)
            ADD_OP, SUB_OP, SLL_OP, SRL_OP, XOR_OP, OR_OP, AND_OP: code_illegal = 1'b0;
            default:                                              code_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ula.sv
// Combinational 32-bit R-type ALU; unsupported codes produce 0.
module ula
    import ula_arb_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT3_W-1:0] funct3_i,
    input  logic [FUNCT7_W-1:0] funct7_i,
    input  logic [31:0]         data1_i,
    input  logic [31:0]         data2_i,
    output logic [31:0]         result_o
);

    logic [CODE_W-1:0] code_s;
    logic              shift_ovf_s;

    assign code_s      = {opcode_i, funct3_i, funct7_i};
    // The whole of data2 is the shift amount, so any upper bit set means >= 32.
    assign shift_ovf_s = |data2_i[31:5];

    // Operation select
    always_comb begin
        result_o = 32'd0;
        case (code_s)
            ADD_OP:  result_o = data1_i + data2_i;
            SUB_OP:  result_o = data1_i - data2_i;
            SLL_OP:  result_o = shift_ovf_s ? 32'd0 : (data1_i << data2_i[4:0]);
            SRL_OP:  result_o = shift_ovf_s ? 32'd0 : (data1_i >> data2_i[4:0]);
            XOR_OP:  result_o = data1_i ^ data2_i;
            OR_OP:   result_o = data1_i | data2_i;
            AND_OP:  result_o = data1_i & data2_i;
            default: result_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/ula_arb_pick.sv
// Two-way grant selector. ULA_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module ula_arb_pick (
    input  logic valid0_i,
    input  logic valid1_i,
`ifdef ULA_ARB_RR_EN
    input  logic prio_i,
`endif
    output logic gnt0_o,
    output logic gnt1_o
);

    // Grant decision
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
`ifdef ULA_ARB_RR_EN
        if (valid0_i && valid1_i) begin
            gnt0_o = ~prio_i;
            gnt1_o = prio_i;
        end else begin
            gnt0_o = valid0_i;
            gnt1_o = valid1_i;
        end
`else
        if (valid0_i) begin
            gnt0_o = 1'b1;
        end else begin
            gnt1_o = valid1_i;
        end
`endif
    end

endmodule

// File: rtl/ula_arb.sv
// Two-port arbiter/sequencer for the shared ula ALU (IDLE -> EXEC -> RESP).
// ULA_ARB_RR_EN enables round-robin arbitration; default is fixed priority to port 0.
module ula_arb
    import ula_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [6:0]        req0_opcode,
    input  logic [2:0]        req0_funct3,
    input  logic [6:0]        req0_funct7,
    input  logic [DATA_W-1:0] req0_data1,
    input  logic [DATA_W-1:0] req0_data2,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_data,
    output logic              resp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [6:0]        req1_opcode,
    input  logic [2:0]        req1_funct3,
    input  logic [6:0]        req1_funct7,
    input  logic [DATA_W-1:0] req1_data1,
    input  logic [DATA_W-1:0] req1_data2,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_data,
    output logic              resp1_err
);

    state_e              state_q, state_d;
    logic [6:0]          opcode_q, opcode_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [6:0]          funct7_q, funct7_d;
    logic [DATA_W-1:0]   data1_q, data1_d;
    logic [DATA_W-1:0]   data2_q, data2_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                err_q, err_d;
    logic                owner_q, owner_d;
    logic                gnt0_s, gnt1_s;
    logic [DATA_W-1:0]   ula_result_s;

`ifdef ULA_ARB_RR_EN
    // Holds the port favoured on the next tie; it moves away from each winner.
    logic                prio_q, prio_d;
`endif

    ula_arb_pick u_pick (
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
`ifdef ULA_ARB_RR_EN
        .prio_i   (prio_q),
`endif
        .gnt0_o   (gnt0_s),
        .gnt1_o   (gnt1_s)
    );

    ula u_ula (
        .opcode_i (opcode_q),
        .funct3_i (funct3_q),
        .funct7_i (funct7_q),
        .data1_i  (data1_q),
        .data2_i  (data2_q),
        .result_o (ula_result_s)
    );

    // Next-state, operand capture and request handshake
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;
        data1_d    = data1_q;
        data2_d    = data2_q;
        result_d   = result_q;
        err_d      = err_q;
        owner_d    = owner_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
`ifdef ULA_ARB_RR_EN
        prio_d     = prio_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt0_s || gnt1_s) begin
                    req0_ready = gnt0_s;
                    req1_ready = gnt1_s;
                    owner_d    = gnt1_s;
                    state_d    = EXEC;
`ifdef ULA_ARB_RR_EN
                    prio_d     = gnt0_s;
`endif
                    if (gnt1_s) begin
                        opcode_d = req1_opcode;
                        funct3_d = req1_funct3;
                        funct7_d = req1_funct7;
                        data1_d  = req1_data1;
                        data2_d  = req1_data2;
                    end else begin
                        opcode_d = req0_opcode;
                        funct3_d = req0_funct3;
                        funct7_d = req0_funct7;
                        data1_d  = req0_data1;
                        data2_d  = req0_data2;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                result_d = ula_result_s;
                err_d    = code_illegal({opcode_q, funct3_q, funct7_q});
                state_d  = RESP;
            end
            RESP: begin
                if (owner_q ? resp1_ready : resp0_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opcode_q <= 7'd0;
            funct3_q <= 3'd0;
            funct7_q <= 7'd0;
            data1_q  <= {DATA_W{1'b0}};
            data2_q  <= {DATA_W{1'b0}};
            result_q <= {DATA_W{1'b0}};
            err_q    <= 1'b0;
            owner_q  <= 1'b0;
`ifdef ULA_ARB_RR_EN
            prio_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct3_q <= funct3_d;
            funct7_q <= funct7_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            result_q <= result_d;
            err_q    <= err_d;
            owner_q  <= owner_d;
`ifdef ULA_ARB_RR_EN
            prio_q   <= prio_d;
`endif
        end
    end

    assign resp0_valid = (state_q == RESP) && !owner_q;
    assign resp1_valid = (state_q == RESP) &&  owner_q;
    assign resp0_data  = resp0_valid ? result_q : {DATA_W{1'b0}};
    assign resp1_data  = resp1_valid ? result_q : {DATA_W{1'b0}};
    assign resp0_err   = resp0_valid & err_q;
    assign resp1_err   = resp1_valid & err_q;

endmodule
